// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IFU/LSU physical-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: IFU wins unless LSU also requests and IFU was served last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   ifu_valid_i,
  input  logic   lsu_valid_i,
  input  owner_e last_i,
  output logic   any_valid_o,
  output owner_e winner_o
);

  always_comb begin
    any_valid_o = ifu_valid_i | lsu_valid_i;
    winner_o    = (ifu_valid_i && (!lsu_valid_i || last_i == OWN_LSU)) ? OWN_IFU : OWN_LSU;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: one outstanding transaction,
// round-robin grant, latched request fields, response routed to the owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W = DEF_ADDR_W,
  parameter  int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DATA_W-1:0] ifu_rsp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DATA_W-1:0] lsu_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              proto_err
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              proto_err_q, proto_err_d;
  logic              any_valid;
  owner_e            winner;
  logic              owner_rsp_ready;

  rr_pick2 u_pick (
    .ifu_valid_i (ifu_req_valid),
    .lsu_valid_i (lsu_req_valid),
    .last_i      (last_q),
    .any_valid_o (any_valid),
    .winner_o    (winner)
  );

  assign owner_rsp_ready = (owner_q == OWN_IFU) ? ifu_rsp_ready : lsu_rsp_ready;

  // Next-state: grant and latch in IDLE, handshake memory, hold response until taken.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rdata_d     = rdata_q;
    proto_err_d = proto_err_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          owner_d = winner;
          last_d  = winner;
          state_d = ISSUE;
          if (winner == OWN_IFU) begin
            addr_d  = ifu_req_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end else begin
            addr_d  = lsu_req_addr;
            wen_d   = lsu_req_wen;
            wdata_d = lsu_req_wdata;
            wmask_d = lsu_req_wmask;
          end
        end
      end
      ISSUE: if (mem_req_ready) state_d = WAIT;
      WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = mem_rsp_data;
          state_d = RESP;
        end
      end
      RESP: if (owner_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A response pulse is only legal while a request is outstanding in WAIT.
    if (mem_rsp_valid && state_q != WAIT) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IFU;
      last_q      <= OWN_LSU;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rdata_q     <= rdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Request ready is a combinational grant in IDLE; everything else decodes registers.
  always_comb begin
    ifu_req_ready = (state_q == IDLE) && any_valid && (winner == OWN_IFU);
    lsu_req_ready = (state_q == IDLE) && any_valid && (winner == OWN_LSU);
    mem_req_valid = (state_q == ISSUE);
    mem_req_addr  = addr_q;
    mem_req_wen   = wen_q;
    mem_req_wdata = wdata_q;
    mem_req_wmask = wmask_q;
    ifu_rsp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
    lsu_rsp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
    ifu_rsp_data  = rdata_q;
    lsu_rsp_data  = rdata_q;
    proto_err     = proto_err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter with directed corner cases.
module tb_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = DW / 8;

  logic          clk, rst_n;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [AW-1:0] ifu_req_addr;
  logic [DW-1:0] ifu_rsp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata, lsu_rsp_data;
  logic [MW-1:0] lsu_req_wmask;
  logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_rsp_data;
  logic [MW-1:0] mem_req_wmask;
  logic          proto_err;

  int n_checks = 0;
  int n_errors = 0;
  bit m_last_ifu = 1'b0;  // model: whether the most recent grant went to the IFU

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: offer requests, model the grant, act as memory, consume response.
  task automatic run_txn(input bit iv, input bit lv, input logic [63:0] ia, input logic [63:0] la,
                         input bit lwen, input logic [63:0] lwd, input logic [7:0] lwm,
                         input logic [63:0] rdata, input int stall, input int wait_c,
                         input int hold, output bit won_ifu);
    bit            exp_ifu;
    logic [63:0]   e_addr, e_wd;
    logic [7:0]    e_wm;
    bit            e_wen;
    exp_ifu = iv && (!lv || !m_last_ifu);
    ifu_req_valid = iv;  ifu_req_addr  = ia;
    lsu_req_valid = lv;  lsu_req_addr  = la;
    lsu_req_wen   = lwen; lsu_req_wdata = lwd; lsu_req_wmask = lwm;
    #1;
    check_eq("ifu_req_ready", 64'(ifu_req_ready), 64'(exp_ifu));
    check_eq("lsu_req_ready", 64'(lsu_req_ready), 64'(!exp_ifu && lv));
    check_eq("mem_req_valid_idle", 64'(mem_req_valid), 64'd0);
    step();
    m_last_ifu = exp_ifu;
    won_ifu    = exp_ifu;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_req_addr = {$urandom, $urandom}; lsu_req_addr = {$urandom, $urandom};
    lsu_req_wdata = {$urandom, $urandom}; lsu_req_wen = ~lsu_req_wen;
    e_addr = exp_ifu ? ia : la;
    e_wen  = exp_ifu ? 1'b0 : lwen;
    e_wd   = exp_ifu ? 64'd0 : lwd;
    e_wm   = exp_ifu ? 8'd0 : lwm;
    mem_req_ready = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) mem_req_ready = 1'b1;
      #1;
      check_eq("mem_req_valid", 64'(mem_req_valid), 64'd1);
      check_eq("mem_req_addr", mem_req_addr, e_addr);
      check_eq("mem_req_wen", 64'(mem_req_wen), 64'(e_wen));
      check_eq("mem_req_wdata", mem_req_wdata, e_wd);
      check_eq("mem_req_wmask", 64'(mem_req_wmask), 64'(e_wm));
      step();
    end
    mem_req_ready = 1'b0;
    for (int w = 0; w < wait_c; w++) begin
      check_eq("wait_no_req", 64'(mem_req_valid), 64'd0);
      check_eq("wait_no_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
      step();
    end
    check_eq("wait_no_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = rdata;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = {$urandom, $urandom};
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_rsp_ready = !exp_ifu; lsu_rsp_ready = exp_ifu;
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) begin
        if (exp_ifu) ifu_rsp_ready = 1'b1; else lsu_rsp_ready = 1'b1;
      end
      #1;
      check_eq("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(exp_ifu));
      check_eq("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(!exp_ifu));
      check_eq("rsp_data", exp_ifu ? ifu_rsp_data : lsu_rsp_data, rdata);
      check_eq("no_grant_in_resp", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      step();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
    check_eq("rsp_dropped", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
  endtask

  initial begin
    bit          won;
    int          r;
    logic [63:0] ra, rb, rw, rd;
    rst_n = 1'b0;
    ifu_req_valid = 0; ifu_req_addr = '0; ifu_rsp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    lsu_rsp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", 64'({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                                   mem_req_valid, mem_req_wen, proto_err}), 64'd0);
    check_eq("reset_addr", mem_req_addr, 64'd0);
    check_eq("reset_wdata", mem_req_wdata, 64'd0);
    check_eq("reset_rsp_data", ifu_rsp_data | lsu_rsp_data, 64'd0);
    rst_n = 1'b1;
    step();

    // Both requesting from reset: grants must alternate starting with IFU.
    for (int i = 0; i < 8; i++) begin
      run_txn(1, 1, 64'h1000 + 64'(i * 8), 64'h2000 + 64'(i * 8), 1'(i % 3 == 0), {$urandom, $urandom},
              8'($urandom), {$urandom, $urandom}, 0, 0, 0, won);
      check_eq("rr_order", 64'(won), 64'(i % 2 == 0));
    end

    run_txn(1, 0, 64'h8000_0000, 64'h0, 0, 64'h0, 8'h0, 64'h0000_0013_0000_0093, 0, 0, 0, won);
    check_eq("ifu_only_won", 64'(won), 64'd1);
    run_txn(0, 1, 64'h0, 64'h8000_1000, 1, 64'h8765_4321_1234_5678, 8'h03, 64'hdead_beef_0000_0001,
            5, 1, 0, won);
    run_txn(0, 1, 64'h0, 64'h8000_2000, 0, 64'h0, 8'h0, 64'h1122_3344_5566_7788, 0, 2, 3, won);

    for (int t = 0; t < 40; t++) begin
      r  = $urandom_range(1, 3);
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rw = {$urandom, $urandom}; rd = {$urandom, $urandom};
      run_txn(1'(r & 1), 1'(r >> 1), ra, rb, 1'($urandom), rw, 8'($urandom), rd,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), won);
    end
    check_eq("no_proto_err", 64'(proto_err), 64'd0);

    // Reset while waiting for memory: transaction dropped, stale pulse flagged.
    lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_3000; lsu_req_wen = 1'b0;
    #1;
    check_eq("pre_rst_grant", 64'(lsu_req_ready), 64'd1);
    step();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check_eq("in_wait", 64'(mem_req_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_clear_addr", mem_req_addr, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hbad0_bad0_bad0_bad0;
    step();
    mem_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("post_rst_no_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
      check_eq("proto_err_sticky", 64'(proto_err), 64'd1);
      step();
    end
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    check_eq("post_rst_idle_tie", 64'({ifu_req_ready, lsu_req_ready}), 64'b10);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single physical-memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU). Accepts one request at a time, arbitrates round-robin, sequences the downstream request/response exchange and routes the response back to the owner. Sits between the core and the pmem DPI wrapper, replacing the ad-hoc per-cycle `pmem_read`/`pmem_write` calls.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width; wmask width is `DATA_W/8`

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `ifu_req_valid`  in  1  IFU read request
- `ifu_req_ready`  out  1  IFU request accepted this cycle
- `ifu_req_addr`  in  ADDR_W  IFU read address
- `ifu_rsp_valid`  out  1  IFU read data valid
- `ifu_rsp_ready`  in  1  IFU takes response
- `ifu_rsp_data`  out  DATA_W  IFU read data
- `lsu_req_valid` / `lsu_req_ready` / `lsu_req_addr`  as IFU
- `lsu_req_wen`  in  1  1 = write, 0 = read
- `lsu_req_wdata`  in  DATA_W  write data
- `lsu_req_wmask`  in  DATA_W/8  byte enables
- `lsu_rsp_valid` / `lsu_rsp_ready` / `lsu_rsp_data`  as IFU; write response returns `mem_rsp_data` unchanged
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`, `mem_req_wen`, `mem_req_wdata`, `mem_req_wmask`  out  latched request fields; IFU requests drive wen=0, wmask=0, wdata=0
- `mem_rsp_valid`  in  1  memory response, single-cycle pulse
- `mem_rsp_data`  in  DATA_W  response data
- `proto_err`  out  1  sticky: `mem_rsp_valid` seen outside WAIT

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Single outstanding transaction.
- IDLE: winner = IFU if `ifu_req_valid && (!lsu_req_valid || last==LSU)`, else LSU if `lsu_req_valid`. Winner's `*_req_ready`=1 (combinational on valid, IDLE only); all request fields latched, `owner` and `last` set to winner; -> ISSUE. No valid -> stay.
- ISSUE: `mem_req_valid`=1, fields stable from latches; on `mem_req_ready` -> WAIT.
- WAIT: on `mem_rsp_valid` latch `mem_rsp_data` -> RESP.
- RESP: owner's `*_rsp_valid`=1 with latched data, held stable; on owner's `*_rsp_ready` -> IDLE. Non-owner `*_rsp_valid`=0 always.
- `mem_rsp_valid` in IDLE/ISSUE/RESP: ignored, sets `proto_err`; cleared only by reset.
- Requesters may drop `*_req_valid` while not granted; arbiter holds no state for them.

## Timing
- Reset (async assert, sync-release use assumed by clock domain): state=IDLE, `last`=LSU (IFU wins first tie), all outputs 0, latches 0, `proto_err`=0.
- Reset mid-transaction: transaction dropped, no response delivered; stale `mem_rsp_valid` then flags `proto_err`.
- Accept at cycle 0 -> `mem_req_valid` at cycle 1. Memory ready at 1 -> WAIT at 2. `mem_rsp_valid` at k -> `*_rsp_valid` at k+1. Ready at k+1 -> IDLE at k+2; next accept possible at k+2.
- Minimum request-to-response: 3 cycles (accept 0, issue 1, rsp 2, deliver 3). Throughput: one transaction per 4 cycles best case.
- Memory must not pulse `mem_rsp_valid` in the same cycle it accepts the request; such a pulse is an error.
- Both requesters valid continuously: grants alternate IFU, LSU, IFU, ...

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/ISSUE/WAIT/RESP), owner enum (OWN_IFU/OWN_LSU), default `ADDR_W`/`DATA_W`.
- Sub-module `rr_pick2`: combinational two-way round-robin winner from two valids and `last`; FSM, latches and routing in top.

## Test plan
- IFU only, addr 0x8000_0000, memory ready immediately, rsp data 0x0000_0013_0000_0093 at cycle 2 -> `ifu_rsp_valid` at cycle 3 with that data; `lsu_rsp_valid` stays 0.
- Both valid from reset, 4 transactions each -> grant order IFU, LSU, IFU, LSU...; no starvation.
- LSU write addr 0x8000_1000, wdata 0x8765_4321_1234_5678, wmask 0x03 -> `mem_req_*` carry exact fields, wen=1; `mem_req_valid` held 5 cycles while `mem_req_ready`=0, fields stable.
- `lsu_rsp_ready` held low 3 cycles in RESP -> `lsu_rsp_valid` and data held; no new grant despite `ifu_req_valid`=1.
- `rst_n` asserted in WAIT, then `mem_rsp_valid` pulse after release -> no `*_rsp_valid`, `proto_err`=1, state IDLE.
